// File: rtl/agc_pkg.sv
// Shared widths, saturation limits and FSM encoding for the AGC stage.
package agc_pkg;
    localparam int DW         = 10;
    localparam int GW         = 6;
    localparam int PW         = DW + GW + 1;
    localparam int GAIN_UNITY = 32;
    localparam int SHIFT      = 5;

    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        UPDATE
    } agc_state_t;
endpackage

// File: rtl/agc_scale.sv
// Gain multiply, arithmetic >>5 (floor) and saturation to DW bits.
// Latency: 2 cycles from data_in/gain to data_out.
// Backpressure: none; accepts one sample every cycle.
module agc_scale
    import agc_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] data_in,
    input  logic [GW-1:0] gain,
    output logic [DW-1:0] data_out
);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_r;
    logic signed [PW-1:0] shifted;
    logic [DW-1:0]        sat_val;
    logic                 pos_ovf;
    logic                 neg_ovf;

    // Gain is an unsigned code, so it gets a zero sign bit before the signed multiply.
    assign prod    = PW'($signed(data_in)) * PW'($signed({1'b0, gain}));
    assign shifted = prod_r >>> SHIFT;

    // Out of range whenever the bits above the output sign disagree with the result sign.
    assign pos_ovf = !shifted[PW-1] &&  (|shifted[PW-2:DW-1]);
    assign neg_ovf =  shifted[PW-1] && !(&shifted[PW-2:DW-1]);

    always_comb begin
        sat_val = shifted[DW-1:0];
        if (pos_ovf) begin
            sat_val = SAT_MAX;
        end else if (neg_ovf) begin
            sat_val = SAT_MIN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_r   <= '0;
            data_out <= '0;
        end else begin
            prod_r   <= prod;
            data_out <= sat_val;
        end
    end
endmodule

// File: rtl/agc_ctrl.sv
// Automatic gain control: scales samples, measures windowed mean |out|, steps gain toward target.
// Latency: data_out 2 cycles after data_in; gain/lock change the cycle after a window's UPDATE.
// Backpressure: none; one sample consumed and produced every cycle.
module agc_ctrl
    import agc_pkg::*;
#(
    parameter int WIN_LOG2  = 10,
    parameter int TARGET    = 128,
    parameter int HYST      = 16,
    parameter int GAIN_INIT = GAIN_UNITY,
    parameter int LOCK_WIN  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] data_in,
    input  logic          agc_en,
    output logic [DW-1:0] data_out,
    output logic [GW-1:0] gain,
    output logic          lock
);
    localparam int AW = DW - 1 + WIN_LOG2;
    localparam int LW = $clog2(LOCK_WIN + 1);

    localparam logic [DW-2:0] HI_LVL   = (DW-1)'(TARGET + HYST);
    localparam logic [DW-2:0] LO_LVL   = (DW-1)'(TARGET - HYST);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WIN);

    agc_state_t          state;
    agc_state_t          state_nxt;
    logic [WIN_LOG2-1:0] cnt;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [DW-2:0]       mean;
    logic [DW-2:0]       mag;
    logic [LW-1:0]       lock_cnt;
    logic                win_end;

    agc_scale u_scale (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .gain     (gain),
        .data_out (data_out)
    );

    // -512 has no positive twin in DW bits, so it folds onto 511.
    assign mag = !data_out[DW-1]       ? data_out[DW-2:0]
               : (data_out == SAT_MIN) ? SAT_MAX[DW-2:0]
               : ~data_out[DW-2:0] + (DW-1)'(1);

    assign acc_sum = acc + AW'(mag);
    assign win_end = (cnt == '1);
    assign lock    = (lock_cnt == LOCK_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (agc_en) state_nxt = ACC;
            ACC: begin
                if (!agc_en) begin
                    state_nxt = IDLE;
                end else if (win_end) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE:  state_nxt = agc_en ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mean     <= '0;
            lock_cnt <= '0;
            gain     <= GW'(GAIN_INIT);
        end else begin
            state <= state_nxt;

            // UPDATE keeps accumulating: its sample is the first of the next window.
            if (state == IDLE || !agc_en) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                cnt <= cnt + WIN_LOG2'(1);
                acc <= win_end ? '0 : acc_sum;
                if (win_end) begin
                    mean <= acc_sum[AW-1:WIN_LOG2];
                end
            end

            if (state == UPDATE) begin
                if (mean > HI_LVL) begin
                    if (gain != '0) gain <= gain - GW'(1);
                    lock_cnt <= '0;
                end else if (mean < LO_LVL) begin
                    if (gain != '1) gain <= gain + GW'(1);
                    lock_cnt <= '0;
                end else if (lock_cnt != LOCK_MAX) begin
                    lock_cnt <= lock_cnt + LW'(1);
                end
            end

            // Leaving closed-loop mode always drops lock, even after a completing UPDATE.
            if (state_nxt == IDLE) begin
                lock_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_agc_ctrl.sv
// Randomised and directed bench for agc_ctrl against an integer behavioural model.
module tb_agc_ctrl;
    logic       clk;
    logic       reset_n;
    logic       agc_en;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic [5:0] gain;
    logic       lock;

    int vectors;
    int miscompares;

    // Reference model: integer arithmetic, sample counts and a pending-update flag.
    int m_p, m_out, m_gain, m_lock, m_n, m_sum, m_mean, m_mag;
    bit m_act, m_pend;

    agc_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .agc_en   (agc_en),
        .data_out (data_out),
        .gain     (gain),
        .lock     (lock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int floor_div32(int p);
        if (p >= 0) return p / 32;
        return -((-p + 31) / 32);
    endfunction

    function automatic int clamp10(int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    task automatic model_reset();
        m_p = 0; m_out = 0; m_gain = 32; m_lock = 0;
        m_n = 0; m_sum = 0; m_mean = 0; m_act = 0; m_pend = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                m_mag = (m_out == -512) ? 511 : ((m_out < 0) ? -m_out : m_out);
                m_out = clamp10(floor_div32(m_p));
                m_p   = $signed(data_in) * m_gain;
                if (m_pend) begin
                    m_pend = 0;
                    if (m_mean > 144) begin
                        m_gain = (m_gain > 0) ? m_gain - 1 : 0;
                        m_lock = 0;
                    end else if (m_mean < 112) begin
                        m_gain = (m_gain < 63) ? m_gain + 1 : 63;
                        m_lock = 0;
                    end else if (m_lock < 4) begin
                        m_lock = m_lock + 1;
                    end
                end
                if (!m_act) begin
                    if (agc_en) begin m_act = 1; m_n = 0; m_sum = 0; end
                end else if (!agc_en) begin
                    m_act = 0; m_n = 0; m_sum = 0; m_lock = 0;
                end else begin
                    m_sum = m_sum + m_mag;
                    m_n   = m_n + 1;
                    if (m_n == 1024) begin
                        m_mean = m_sum / 1024;
                        m_pend = 1; m_n = 0; m_sum = 0;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0; agc_en = 1'b0; data_in = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; agc_en = 1'b1; data_in = 10'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== 10'd0) begin miscompares++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
            vectors++;
            if (gain !== 6'd32) begin miscompares++; $display("FAIL reset_gain: got %0d want 32", gain); end
            vectors++;
            if (lock !== 1'b0) begin miscompares++; $display("FAIL reset_lock: got %0b want 0", lock); end
        end
    endtask

    task automatic test_lock_128();
        apply_reset();
        data_in = 10'd128; agc_en = 1'b1;
        for (int i = 1; i <= 5 * 1024 + 8; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL lock128 t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (i == 4097 || i == 4098) begin
                vectors++;
                if (lock !== (i == 4098)) begin miscompares++; $display("FAIL lock128_edge cycle %0d: lock=%0b want %0b", i, lock, i == 4098); end
            end
        end
        vectors++;
        if (gain !== 6'd32 || lock !== 1'b1) begin miscompares++; $display("FAIL lock128_final: gain=%0d lock=%0b want 32 1", gain, lock); end
    endtask

    task automatic test_large();
        apply_reset();
        data_in = 10'd400; agc_en = 1'b1;
        for (int i = 1; i <= 3 * 1024 + 4; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL large t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
        end
        vectors++;
        if (gain !== 6'd29 || lock !== 1'b0) begin miscompares++; $display("FAIL large_final: gain=%0d lock=%0b want 29 0", gain, lock); end
    endtask

    task automatic test_drop();
        bit found;
        int g0;
        found = 0;
        for (int i = 0; i < 1200 && !found; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL drop_wait t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (m_act && m_n == 500) found = 1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL drop_timeout: sample 500 not reached, got 0 want 1"); end
        g0 = m_gain;
        agc_en = 1'b0; data_in = '0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL drop_idle t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
        end
        vectors++;
        if (gain !== g0[5:0] || lock !== 1'b0) begin miscompares++; $display("FAIL drop_frozen: gain=%0d lock=%0b want %0d 0", gain, lock, g0); end
        agc_en = 1'b1;
        for (int i = 1; i <= 1026; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL drop_reen t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (i >= 1025) begin
                vectors++;
                if (gain !== 6'(g0 + i - 1025)) begin miscompares++; $display("FAIL drop_update_time cycle %0d: gain=%0d want %0d", i, gain, g0 + i - 1025); end
            end
        end
    endtask

    task automatic test_ramp();
        bit done;
        apply_reset();
        data_in = 10'd64; agc_en = 1'b1;
        done = 0;
        for (int i = 0; i < 40 * 1024 && !done; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL ramp t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (m_lock >= 4) done = 1;
        end
        vectors++;
        if (!done || lock !== 1'b1 || gain < 6'd56 || gain > 6'd57) begin
            miscompares++;
            $display("FAIL ramp_final: gain=%0d lock=%0b want gain 56..57 lock 1", gain, lock);
        end
    endtask

    task automatic test_ceiling();
        bit done;
        data_in = '0;
        done = 0;
        for (int i = 0; i < 12 * 1024 && !done; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL ceiling_climb t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (m_gain == 63) done = 1;
        end
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL ceiling_hold t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
        end
        vectors++;
        if (!done || gain !== 6'd63 || lock !== 1'b0) begin miscompares++; $display("FAIL ceiling_final: gain=%0d lock=%0b want 63 0", gain, lock); end
    endtask

    task automatic test_saturation();
        int sat_in[3]  = '{511, -512, -1};
        int sat_exp[3] = '{511, -512, -2};
        int v;
        agc_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (gain !== 6'd63) begin miscompares++; $display("FAIL sat_gain: got %0d want 63", gain); end
        for (int k = 0; k < 3; k++) begin
            v = sat_in[k];
            data_in = v[9:0];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                vectors++;
                if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                    miscompares++;
                    $display("FAIL sat_model t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
                end
            end
            v = sat_exp[k];
            vectors++;
            if (data_out !== v[9:0]) begin miscompares++; $display("FAIL sat_%0d: data_out=%0d want %0d", k, $signed(data_out), sat_exp[k]); end
        end
    endtask

    task automatic test_relock();
        data_in = 10'd65; agc_en = 1'b1;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL relock t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
        end
        vectors++;
        if (lock !== 1'b1 || gain !== 6'd63 || data_out !== 10'd127) begin
            miscompares++;
            $display("FAIL relock_final: gain=%0d lock=%0b out=%0d want 63 1 127", gain, lock, data_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (data_out !== 10'd0) begin miscompares++; $display("FAIL async_data_out: got %0d want 0", data_out); end
        vectors++;
        if (gain !== 6'd32) begin miscompares++; $display("FAIL async_gain: got %0d want 32", gain); end
        vectors++;
        if (lock !== 1'b0) begin miscompares++; $display("FAIL async_lock: got %0b want 0", lock); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int amp;
        int v;
        apply_reset();
        agc_en = 1'b1;
        amp = 200;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            vectors++;
            if (data_out !== m_out[9:0] || gain !== m_gain[5:0] || lock !== (m_lock >= 4)) begin
                miscompares++;
                $display("FAIL random t=%0t: out=%0d gain=%0d lock=%0b want %0d %0d %0b", $time, $signed(data_out), gain, lock, m_out, m_gain, m_lock >= 4);
            end
            if (i % 1024 == 0) amp = int'($urandom_range(0, 511));
            v = int'($urandom_range(0, 2 * amp)) - amp;
            data_in = v[9:0];
            if ($urandom_range(0, 1499) == 0) agc_en = ~agc_en;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        agc_en = 1'b0;
        data_in = '0;
        test_reset();
        test_lock_128();
        test_large();
        test_drop();
        test_ramp();
        test_ceiling();
        test_saturation();
        test_relock();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
